// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell processes a - b LSB first,
// one bit per clock, with a start/done handshake.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             bor;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bor_next;

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bor),
        .d    (d_bit),
        .bout (bor_next)
    );

    // diff/borrow_out change only on entry to DONE, so they hold through IDLE and the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bor   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d_bit, res[WIDTH-1:1]};
                    bor  <= bor_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff       <= {d_bit, res[WIDTH-1:1]};
                        borrow_out <= bor_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors, back-to-back,
// asynchronous mid-run reset and a spread operand sweep.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge at which done is first seen.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 output int lat, output int busyCnt);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        lat     = 0;
        busyCnt = 0;
        while (!done && lat < 20) begin
            busyCnt += int'(busy);
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
    endtask

    logic [W-1:0] bbA [3] = '{8'd30, 8'd7,   8'd128};
    logic [W-1:0] bbB [3] = '{8'd12, 8'd9,   8'd255};
    logic [W-1:0] bbD [3] = '{8'd18, 8'hFE,  8'h81};
    logic         bbR [3] = '{1'b0,  1'b1,   1'b1};

    initial begin
        int lat, busyCnt, cyc, lastCyc, idx;
        logic [W:0] t;
        logic [W-1:0] sa, sb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'd9, 8'd5, lat, busyCnt);
        checkOutput("lat_9m5", 32'(lat), 32'd8);
        checkOutput("busy_cycles", 32'(busyCnt), 32'd8);
        checkOutput("diff_9m5", 32'(diff), 32'd4);
        checkOutput("bor_9m5", 32'(borrow_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("hold_diff", 32'(diff), 32'd4);

        applyStimulus(8'd5, 8'd9, lat, busyCnt);
        checkOutput("diff_5m9", 32'(diff), 32'hFC);
        checkOutput("bor_5m9", 32'(borrow_out), 32'd1);

        applyStimulus(8'd0, 8'd1, lat, busyCnt);
        checkOutput("diff_0m1", 32'(diff), 32'hFF);
        checkOutput("bor_0m1", 32'(borrow_out), 32'd1);
        applyStimulus(8'hFF, 8'hFF, lat, busyCnt);
        checkOutput("lat_b2b", 32'(lat), 32'd8);
        checkOutput("diff_ffmff", 32'(diff), 32'd0);
        checkOutput("bor_ffmff", 32'(borrow_out), 32'd0);
        @(posedge clk);
        #1;

        // start held high with operands churning; only the pair driven at an accepting edge counts
        start   = 1'b1;
        a       = bbA[0];
        b       = bbB[0];
        idx     = 0;
        cyc     = 0;
        lastCyc = 0;
        while (idx < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                checkOutput("bb_diff", 32'(diff), 32'(bbD[idx]));
                checkOutput("bb_borrow", 32'(borrow_out), 32'(bbR[idx]));
                checkOutput("bb_gap", 32'(cyc - lastCyc), 32'd9);
                lastCyc = cyc;
                idx++;
                if (idx < 3) begin
                    a = bbA[idx];
                    b = bbB[idx];
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        checkOutput("bb_count", 32'(idx), 32'd3);
        start = 1'b0;
        @(posedge clk);
        #1;

        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        checkOutput("async_diff", 32'(diff), 32'd0);
        checkOutput("async_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        applyStimulus(8'd200, 8'd100, lat, busyCnt);
        checkOutput("lat_200m100", 32'(lat), 32'd8);
        checkOutput("diff_200m100", 32'(diff), 32'd100);
        checkOutput("bor_200m100", 32'(borrow_out), 32'd0);

        // 64x64 grid spread over the operand range, including 0 and 255 on both sides
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                sa = {i[5:0], i[1:0]};
                sb = {j[5:0], j[1:0]};
                t  = {1'b0, sa} - {1'b0, sb};
                applyStimulus(sa, sb, lat, busyCnt);
                checkOutput("sweep_diff", 32'(diff), 32'(t[W-1:0]));
                checkOutput("sweep_borrow", 32'(borrow_out), 32'(sa < sb));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
